dma_count_ctrl: RTL and testbench
=================================

# dma_count_ctrl

Sequencer that drives one loadable up/down transfer counter in the DMA datapath. On a start request it presets the counter via its active-low load strobe and waits for the load acknowledge. It then asserts count-enable for exactly the requested number of steps and checks the final count against the arithmetic expectation. Completion or error is reported to the DMA channel logic.

## Interface
- WIDTH, 10, counter width; all count/data buses use it.
- clk  in  1  rising-edge clock, shared with the counter.
- MR  in  1  synchronous, active-high reset; acts only on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- start_value  in  WIDTH  preset written into the counter.
- length  in  WIDTH  number of count steps N; 0 is legal.
- up  in  1  1 = increment, 0 = decrement.
- busy  out  1  high from the cycle after start is accepted until done/err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on load-ack timeout or final-count mismatch; exclusive with done.
- wrap  out  1  registered at accept: carry out of start_value+length (up) or borrow of start_value−length (down).
- cnt_data  out  WIDTH  preset value to the counter.
- cnt_load_n  out  1  active-low load strobe.
- cnt_en  out  1  count enable.
- cnt_dir  out  1  direction; equals the latched up.
- cnt_loadDone  in  1  load acknowledge from the counter.
- cnt_count  in  WIDTH  current counter value.

## Operation
- Reset values: busy=0, done=0, err=0, wrap=0, cnt_load_n=1, cnt_en=0, cnt_dir=0, cnt_data=0, state IDLE.
- All outputs are registered.
- States: IDLE, LOAD, ACK, RUN, DRAIN, CHECK.
- **IDLE.** If start=1: latch start_value, length, up and wrap; compute expected = start_value ± length mod 2^WIDTH; go to LOAD. Otherwise stay in IDLE.
- **LOAD.** One cycle only: cnt_load_n=0, cnt_data=latched start_value. Then go to ACK.
- **ACK.** cnt_load_n=1.
  - cnt_loadDone=1: go to RUN if N>0, or to CHECK if N=0.
  - 4 consecutive ACK cycles without cnt_loadDone: pulse err, return to IDLE.
- **RUN.** cnt_en=1 for exactly N consecutive cycles, tracked by an internal WIDTH-bit step counter. After the Nth cycle, go to DRAIN.
  - The counter's registered FSM turns N enable cycles into exactly N steps. The last step lands on the edge ending DRAIN.
- **DRAIN.** One cycle with cnt_en=0. Then go to CHECK.
- **CHECK.** cnt_count==expected → pulse done; otherwise pulse err. busy drops in the same cycle. Return to IDLE.
- **Held values.** cnt_dir and cnt_data stay at their latched values from LOAD through CHECK. The counter's carry flag depends on cnt_dir.
- **start ignored when not IDLE.** A start while busy has no effect and is not queued.
- **MR mid-operation.** At the next edge, all outputs return to reset values, including cnt_en=0 and cnt_load_n=1. The counter value is left unchanged, since this block does not reset the counter. No done/err pulse is produced.
- **Wrap-around.** Counter wrap is legal. expected uses modular arithmetic and wrap flags the wrap.

## Timing
- start high in cycle t (IDLE):
  - LOAD (cnt_load_n=0) in t+1.
  - ACK from t+2.
  - With a conforming counter, cnt_loadDone is high in t+3.
- RUN occupies t+4 … t+3+N; DRAIN is t+4+N; CHECK is t+5+N.
- done/err high in t+6+N, with busy=0 in that cycle. A new start is accepted in that same cycle.
- N=0: ACK → CHECK at t+4; done at t+5.
- Latency from accept to result is N+6 cycles.
- Throughput is one transfer per N+6 cycles.

## Test plan
- Reset then start, start_value=0x005, length=3, up=1 → cnt_load_n low for 1 cycle; cnt_en high exactly 3 cycles; cnt_count=0x008; done pulse at t+9; err=0; wrap=0.
- start_value=0x3FE, length=4, up=1 → wrap=1 at accept; final count=0x002; done at t+10.
- start_value=0x002, length=5, down → wrap=1; final count=0x3FD; done.
- length=0, start_value=0x155 → no cnt_en pulse; count=0x155; done at t+5.
- cnt_loadDone tied low → err pulse after 4 ACK cycles; cnt_en never asserted; busy returns to 0.
- MR asserted during RUN of length=100 → next edge: cnt_en=0, busy=0, no done/err. A start re-pulsed the following cycle is accepted. A second start issued while busy is ignored.

Source files
------------

// File: rtl/dma_count_ctrl.sv
// Sequencer for one loadable up/down transfer counter: presets it, waits for the
// load acknowledge, enables it for N steps, then checks the final count.
module dma_count_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             MR,
  input  logic             start,
  input  logic [WIDTH-1:0] start_value,
  input  logic [WIDTH-1:0] length,
  input  logic             up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_load_n,
  output logic             cnt_en,
  output logic             cnt_dir,
  input  logic             cnt_loadDone,
  input  logic [WIDTH-1:0] cnt_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ACK   = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] CHECK = 3'd5;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg;
  logic [WIDTH-1:0] len_reg;
  logic [WIDTH-1:0] expected_reg;
  logic [WIDTH-1:0] step_reg;
  logic [1:0]       ack_cnt_reg;

  // One extra bit captures the carry (up) or borrow (down) of the end value.
  logic [WIDTH:0] end_next;

  always_comb begin
    end_next = '0;
    if (up)
      end_next = {1'b0, start_value} + {1'b0, length};
    else
      end_next = {1'b0, start_value} - {1'b0, length};
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      expected_reg <= '0;
      step_reg     <= '0;
      ack_cnt_reg  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wrap         <= 1'b0;
      cnt_data     <= '0;
      cnt_load_n   <= 1'b1;
      cnt_en       <= 1'b0;
      cnt_dir      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg      <= length;
            expected_reg <= end_next[WIDTH-1:0];
            wrap         <= end_next[WIDTH];
            cnt_data     <= start_value;
            cnt_dir      <= up;
            cnt_load_n   <= 1'b0;
            busy         <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          cnt_load_n  <= 1'b1;
          ack_cnt_reg <= '0;
          state_reg   <= ACK;
        end
        ACK: begin
          if (cnt_loadDone) begin
            if (len_reg != '0) begin
              cnt_en    <= 1'b1;
              step_reg  <= '0;
              state_reg <= RUN;
            end else begin
              state_reg <= CHECK;
            end
          end else if (ack_cnt_reg == 2'd3) begin
            // Fourth silent ACK cycle: give up on the counter.
            err       <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            ack_cnt_reg <= ack_cnt_reg + 2'd1;
          end
        end
        RUN: begin
          if (step_reg == len_reg - ONE) begin
            cnt_en    <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            step_reg <= step_reg + ONE;
          end
        end
        DRAIN: begin
          // The counter's last step lands on the edge ending this cycle.
          state_reg <= CHECK;
        end
        CHECK: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
          if (cnt_count == expected_reg)
            done <= 1'b1;
          else
            err <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_count_ctrl.sv
// Directed bench for dma_count_ctrl with a behavioural model of the attached
// counter (one-cycle registered response to load and enable).
module tb_dma_count_ctrl;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             MR = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] start_value = '0;
  logic [WIDTH-1:0] length = '0;
  logic             up = 1'b0;
  logic             busy, done, err, wrap;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_load_n, cnt_en, cnt_dir;
  logic             cnt_loadDone;
  logic [WIDTH-1:0] cnt_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .MR(MR), .start(start), .start_value(start_value),
    .length(length), .up(up), .busy(busy), .done(done), .err(err),
    .wrap(wrap), .cnt_data(cnt_data), .cnt_load_n(cnt_load_n),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_loadDone(cnt_loadDone),
    .cnt_count(cnt_count)
  );

  // Counter model: load and enable each take effect one edge after they are seen.
  logic             ack_enable = 1'b1;
  logic             ld_d = 1'b0;
  logic             en_d = 1'b0;
  logic             ld_done_m = 1'b0;
  logic [WIDTH-1:0] count_m = '0;

  always @(posedge clk) begin
    ld_d      <= ~cnt_load_n;
    en_d      <= cnt_en;
    ld_done_m <= ld_d;
    if (ld_d)
      count_m <= cnt_data;
    else if (en_d)
      count_m <= cnt_dir ? count_m + 10'd1 : count_m - 10'd1;
  end

  assign cnt_loadDone = ld_done_m & ack_enable;
  assign cnt_count    = count_m;

  // Observations of the last transfer (gathered only; each test compares).
  int               o_cyc, o_load_low, o_en, o_busy1, o_busy_end;
  logic             o_done, o_err, o_wrap, o_dir;
  logic [WIDTH-1:0] o_data, o_count;

  // Caller is just past a negedge; start is driven in this cycle (cycle t).
  task automatic run_xfer(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] len,
                          input logic dir);
    start = 1'b1; start_value = sv; length = len; up = dir;
    o_cyc = 0; o_load_low = 0; o_en = 0; o_done = 0; o_err = 0;
    o_busy1 = 0; o_busy_end = 1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        o_wrap = wrap; o_dir = cnt_dir; o_data = cnt_data; o_busy1 = int'(busy);
      end
      if (!cnt_load_n) o_load_low++;
      if (cnt_en) o_en++;
      if (done || err) begin
        o_cyc = c; o_done = done; o_err = err; o_busy_end = int'(busy);
        o_count = cnt_count;
        break;
      end
    end
  endtask

  task automatic check_xfer(input string name, input int exp_cyc, input int exp_en,
                            input logic exp_done, input logic exp_wrap,
                            input logic [WIDTH-1:0] exp_count);
    checks++;
    if (o_cyc !== exp_cyc) begin
      errors++; $display("FAIL %s result_cycle got t+%0d want t+%0d", name, o_cyc, exp_cyc);
    end
    checks++;
    if (o_done !== exp_done || o_err !== !exp_done) begin
      errors++; $display("FAIL %s done/err got %b/%b want %b/%b", name, o_done, o_err, exp_done, !exp_done);
    end
    checks++;
    if (o_en !== exp_en) begin
      errors++; $display("FAIL %s en_cycles got %0d want %0d", name, o_en, exp_en);
    end
    checks++;
    if (o_wrap !== exp_wrap) begin
      errors++; $display("FAIL %s wrap got %b want %b", name, o_wrap, exp_wrap);
    end
    checks++;
    if (o_load_low !== 1 || o_busy1 !== 1 || o_busy_end !== 0) begin
      errors++; $display("FAIL %s load_low/busy1/busy_end got %0d/%0d/%0d want 1/1/0", name, o_load_low, o_busy1, o_busy_end);
    end
    if (exp_done) begin
      checks++;
      if (o_count !== exp_count) begin
        errors++; $display("FAIL %s count got %h want %h", name, o_count, exp_count);
      end
    end
    $display("xfer %s: result t+%0d done=%b err=%b en=%0d wrap=%b count=%h", name, o_cyc, o_done, o_err, o_en, o_wrap, o_count);
  endtask

  task automatic test_reset;
    MR = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, wrap, cnt_load_n, cnt_en, cnt_dir} !== 7'b0000100 || cnt_data !== '0) begin
      errors++;
      $display("FAIL reset outputs got b%b d%b e%b w%b ln%b en%b dir%b data%h want 0 0 0 0 1 0 0 000",
               busy, done, err, wrap, cnt_load_n, cnt_en, cnt_dir, cnt_data);
    end
    MR = 1'b0;
    @(negedge clk);
    $display("reset: outputs sampled after 2 reset cycles");
  endtask

  task automatic test_up_basic;
    run_xfer(10'h005, 10'd3, 1'b1);
    check_xfer("up_basic", 9, 3, 1'b1, 1'b0, 10'h008);
    checks++;
    if (o_dir !== 1'b1 || o_data !== 10'h005) begin
      errors++; $display("FAIL up_basic dir/data got %b/%h want 1/005", o_dir, o_data);
    end
  endtask

  task automatic test_up_wrap;
    @(negedge clk);
    run_xfer(10'h3FE, 10'd4, 1'b1);
    check_xfer("up_wrap", 10, 4, 1'b1, 1'b1, 10'h002);
  endtask

  task automatic test_down_wrap;
    @(negedge clk);
    run_xfer(10'h002, 10'd5, 1'b0);
    check_xfer("down_wrap", 11, 5, 1'b1, 1'b1, 10'h3FD);
    checks++;
    if (o_dir !== 1'b0) begin
      errors++; $display("FAIL down_wrap dir got %b want 0", o_dir);
    end
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    run_xfer(10'h155, 10'd0, 1'b1);
    check_xfer("zero_len", 5, 0, 1'b1, 1'b0, 10'h155);
  endtask

  task automatic test_back_to_back;
    // New start is issued in the very cycle the previous done is high.
    @(negedge clk);
    run_xfer(10'h020, 10'd2, 1'b1);
    check_xfer("b2b_first", 8, 2, 1'b1, 1'b0, 10'h022);
    run_xfer(10'h100, 10'd1, 1'b0);
    check_xfer("b2b_second", 7, 1, 1'b1, 1'b0, 10'h0FF);
  endtask

  task automatic test_ack_timeout;
    ack_enable = 1'b0;
    @(negedge clk);
    run_xfer(10'h011, 10'd6, 1'b1);
    check_xfer("ack_timeout", 6, 0, 1'b0, 1'b0, 10'h000);
    ack_enable = 1'b1;
  endtask

  task automatic test_mr_midrun;
    int en_seen;
    @(negedge clk);
    start = 1'b1; start_value = 10'h000; length = 10'd100; up = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_seen = 0;
    for (int c = 0; c < 40 && en_seen < 10; c++) begin
      @(negedge clk);
      if (cnt_en) en_seen++;
    end
    checks++;
    if (en_seen !== 10) begin
      errors++; $display("FAIL mr_run_reached en_cycles got %0d want 10", en_seen);
    end
    // A start while busy must neither disturb nor be queued.
    start = 1'b1; start_value = 10'h3FF; length = 10'd1; up = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cnt_en !== 1'b1 || cnt_data !== 10'h000 || cnt_dir !== 1'b1) begin
      errors++; $display("FAIL ignored_start got busy%b en%b data%h dir%b want 1 1 000 1", busy, cnt_en, cnt_data, cnt_dir);
    end
    MR = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, cnt_en, cnt_load_n} !== 5'b00001) begin
      errors++; $display("FAIL mr_midrun got busy%b done%b err%b en%b ln%b want 0 0 0 0 1", busy, done, err, cnt_en, cnt_load_n);
    end
    $display("mr_midrun: busy=%b en=%b done=%b err=%b", busy, cnt_en, done, err);
    MR = 1'b0;
    run_xfer(10'h010, 10'd2, 1'b1);
    check_xfer("after_mr", 8, 2, 1'b1, 1'b0, 10'h012);
  endtask

  initial begin
    test_reset;
    test_up_basic;
    test_up_wrap;
    test_down_wrap;
    test_zero_len;
    test_back_to_back;
    test_ack_timeout;
    test_mr_midrun;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
